// File: rtl/word_splitter_16bit.sv
// Splits 16-bit words into two byte transfers with loadhigh/loadlow strobes.
// Optional one-word prefetch holding register enabled by WORD_SPLITTER_PREFETCH_EN.
module word_splitter_16bit #(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wordvalid,
    input  logic [15:0] wordin,
    output logic        wordready,
    output logic [7:0]  halfvalueout,
    output logic        loadhigh,
    output logic        loadlow,
    input  logic        byteready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SEND_FIRST  = 2'd1,
        SEND_SECOND = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [15:0] r_active;
    logic [15:0] w_nextActive;
    logic [7:0]  r_byte;
    logic [7:0]  w_nextByte;
    logic        r_loadHigh;
    logic        r_loadLow;
    logic        w_nextHigh;
    logic        w_nextLow;
    logic        w_accept;
    logic        w_xfer;

`ifdef WORD_SPLITTER_PREFETCH_EN
    logic [15:0] r_hold;
    logic [15:0] w_nextHold;
    logic        r_holdValid;
    logic        w_nextHoldValid;

    assign wordready = !r_holdValid;
    assign busy      = (r_state != IDLE) || r_holdValid;
`else
    assign wordready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
`endif

    assign w_accept     = wordvalid && wordready;
    assign w_xfer       = (r_state != IDLE) && byteready;
    assign halfvalueout = r_byte;
    assign loadhigh     = r_loadHigh;
    assign loadlow      = r_loadLow;

    always_comb begin
        w_nextState  = r_state;
        w_nextActive = r_active;
`ifdef WORD_SPLITTER_PREFETCH_EN
        w_nextHold      = r_hold;
        w_nextHoldValid = r_holdValid;
`endif
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextActive = wordin;
                    w_nextState  = SEND_FIRST;
                end
            end
            SEND_FIRST: begin
                if (w_xfer) begin
                    w_nextState = SEND_SECOND;
                end
`ifdef WORD_SPLITTER_PREFETCH_EN
                if (w_accept) begin
                    w_nextHold      = wordin;
                    w_nextHoldValid = 1'b1;
                end
`endif
            end
            SEND_SECOND: begin
`ifdef WORD_SPLITTER_PREFETCH_EN
                // A word arriving as the last byte leaves bypasses the empty hold.
                if (w_xfer) begin
                    if (r_holdValid) begin
                        w_nextActive    = r_hold;
                        w_nextHoldValid = 1'b0;
                        w_nextState     = SEND_FIRST;
                    end else if (w_accept) begin
                        w_nextActive = wordin;
                        w_nextState  = SEND_FIRST;
                    end else begin
                        w_nextState = IDLE;
                    end
                end else if (w_accept) begin
                    w_nextHold      = wordin;
                    w_nextHoldValid = 1'b1;
                end
`else
                if (w_xfer) begin
                    w_nextState = IDLE;
                end
`endif
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so they can be registered.
    always_comb begin
        w_nextByte = 8'h00;
        w_nextHigh = 1'b0;
        w_nextLow  = 1'b0;
        case (w_nextState)
            SEND_FIRST: begin
                w_nextByte = HIGH_FIRST ? w_nextActive[15:8] : w_nextActive[7:0];
                w_nextHigh = HIGH_FIRST;
                w_nextLow  = !HIGH_FIRST;
            end
            SEND_SECOND: begin
                w_nextByte = HIGH_FIRST ? w_nextActive[7:0] : w_nextActive[15:8];
                w_nextHigh = !HIGH_FIRST;
                w_nextLow  = HIGH_FIRST;
            end
            default: begin
                w_nextByte = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_active   <= 16'h0000;
            r_byte     <= 8'h00;
            r_loadHigh <= 1'b0;
            r_loadLow  <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_active   <= w_nextActive;
            r_byte     <= w_nextByte;
            r_loadHigh <= w_nextHigh;
            r_loadLow  <= w_nextLow;
        end
    end

`ifdef WORD_SPLITTER_PREFETCH_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hold      <= 16'h0000;
            r_holdValid <= 1'b0;
        end else begin
            r_hold      <= w_nextHold;
            r_holdValid <= w_nextHoldValid;
        end
    end
`endif

endmodule

// File: tb/tb_word_splitter_16bit.sv
// Self-checking bench for word_splitter_16bit: two instances (high-first and
// low-first) share stimulus and are compared against a queue-based word model.
module tb_word_splitter_16bit;

    typedef struct {
        logic [15:0] word;
        logic [7:0]  aFirst;
        logic [7:0]  aSecond;
        logic [7:0]  bFirst;
        logic [7:0]  bSecond;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        wordvalid;
    logic [15:0] wordin;
    logic        byteready;

    logic        wordReadyA, loadHighA, loadLowA, busyA;
    logic [7:0]  halfA;
    logic        wordReadyB, loadHighB, loadLowB, busyB;
    logic [7:0]  halfB;

    int checks = 0;
    int errors = 0;

    logic [15:0] modelQ[$];
    int          modelSent;
    logic [15:0] asmA;
    int          cycleCount = 0;

    vec_t vecs[6];

    word_splitter_16bit #(.HIGH_FIRST(1'b1)) dutA (
        .clock(clock), .reset(reset), .wordvalid(wordvalid), .wordin(wordin),
        .wordready(wordReadyA), .halfvalueout(halfA), .loadhigh(loadHighA),
        .loadlow(loadLowA), .byteready(byteready), .busy(busyA)
    );

    word_splitter_16bit #(.HIGH_FIRST(1'b0)) dutB (
        .clock(clock), .reset(reset), .wordvalid(wordvalid), .wordin(wordin),
        .wordready(wordReadyB), .halfvalueout(halfB), .loadhigh(loadHighB),
        .loadlow(loadLowB), .byteready(byteready), .busy(busyB)
    );

    always #5 clock = ~clock;

    task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic expReady();
`ifdef WORD_SPLITTER_PREFETCH_EN
        return modelQ.size() < 2;
`else
        return modelQ.size() == 0;
`endif
    endfunction

    // Expected {wordready, busy, loadhigh, loadlow, byte} for both instances.
    task automatic checkOutput();
        logic [11:0] expA;
        logic [11:0] expB;
        logic [15:0] w;
        expA = {expReady(), 3'b000, 8'h00};
        expB = expA;
        if (modelQ.size() != 0) begin
            w = modelQ[0];
            if (modelSent == 0) begin
                expA = {expReady(), 1'b1, 2'b10, w[15:8]};
                expB = {expReady(), 1'b1, 2'b01, w[7:0]};
            end else begin
                expA = {expReady(), 1'b1, 2'b01, w[7:0]};
                expB = {expReady(), 1'b1, 2'b10, w[15:8]};
            end
        end
        checkVal("outputs A", {4'h0, wordReadyA, busyA, loadHighA, loadLowA, halfA}, {4'h0, expA});
        checkVal("outputs B", {4'h0, wordReadyB, busyB, loadHighB, loadLowB, halfB}, {4'h0, expB});
    endtask

    // Called at a falling edge; advances one clock cycle and the model with it.
    task automatic applyStimulus(input logic v, input logic [15:0] w, input logic br);
        logic acc;
        logic xfer;
        checkOutput();
        wordvalid = v;
        wordin    = w;
        byteready = br;
        if (loadHighA && br) asmA[15:8] = halfA;
        if (loadLowA && br)  asmA[7:0]  = halfA;
        acc  = v && expReady();
        xfer = (modelQ.size() != 0) && br;
        if (xfer) begin
            if (modelSent == 1) begin
                void'(modelQ.pop_front());
                modelSent = 0;
            end else begin
                modelSent = 1;
            end
        end
        if (acc) modelQ.push_back(w);
        @(posedge clock);
        cycleCount++;
        @(negedge clock);
    endtask

    task automatic doReset();
        reset = 1'b0;
        modelQ.delete();
        modelSent = 0;
        asmA = 16'h0000;
        #1;
        checkOutput();
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic sendWord(input vec_t v);
        applyStimulus(1'b1, v.word, 1'b1);
        checkVal("first byte A", {6'h0, loadHighA, loadLowA, halfA}, {6'h0, 2'b10, v.aFirst});
        checkVal("first byte B", {6'h0, loadHighB, loadLowB, halfB}, {6'h0, 2'b01, v.bFirst});
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkVal("second byte A", {6'h0, loadHighA, loadLowA, halfA}, {6'h0, 2'b01, v.aSecond});
        checkVal("second byte B", {6'h0, loadHighB, loadLowB, halfB}, {6'h0, 2'b10, v.bSecond});
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkVal("assembled word", asmA, v.word);
    endtask

    initial begin
        logic [15:0] b2bWords[3];
        logic [7:0]  gotBytes[$];
        int          gotCycles[$];
        int          idx;
        int          expSpan;
        logic        acc;
        logic        v;
        logic [15:0] w;

        vecs[0] = '{16'hA55A, 8'hA5, 8'h5A, 8'h5A, 8'hA5};
        vecs[1] = '{16'hBEEF, 8'hBE, 8'hEF, 8'hEF, 8'hBE};
        vecs[2] = '{16'h0000, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3] = '{16'hFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[4] = '{16'h00FF, 8'h00, 8'hFF, 8'hFF, 8'h00};
        vecs[5] = '{16'h0BAD, 8'h0B, 8'hAD, 8'hAD, 8'h0B};

        wordvalid = 1'b0;
        wordin    = 16'h0000;
        byteready = 1'b1;
        reset     = 1'b1;
        modelSent = 0;
        asmA      = 16'h0000;
        @(negedge clock);
        doReset();
        checkVal("reset state A", {11'h0, wordReadyA, busyA, loadHighA, loadLowA, 1'b0} | {8'h0, halfA}, 16'h0010);

        for (int i = 0; i < 6; i++) sendWord(vecs[i]);

        // Stall in the first byte for four cycles.
        applyStimulus(1'b1, 16'h1234, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkVal("stall hold", {6'h0, loadHighA, loadLowA, halfA}, {6'h0, 2'b10, 8'h12});
            applyStimulus(1'b0, 16'hFFFF, 1'b0);
        end
        checkVal("stall hold", {6'h0, loadHighA, loadLowA, halfA}, {6'h0, 2'b10, 8'h12});
        applyStimulus(1'b0, 16'hFFFF, 1'b1);
        checkVal("after stall", {6'h0, loadHighA, loadLowA, halfA}, {6'h0, 2'b01, 8'h34});
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkVal("stall word", asmA, 16'h1234);

        // Back-to-back words with wordvalid held high.
        b2bWords[0] = 16'h0102;
        b2bWords[1] = 16'h0304;
        b2bWords[2] = 16'h0506;
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            if (loadHighA || loadLowA) begin
                gotBytes.push_back(halfA);
                gotCycles.push_back(c);
            end
            v   = (idx < 3);
            w   = v ? b2bWords[idx] : 16'h0000;
            acc = v && expReady();
            applyStimulus(v, w, 1'b1);
            if (acc) idx++;
        end
`ifdef WORD_SPLITTER_PREFETCH_EN
        expSpan = 5;
`else
        expSpan = 7;
`endif
        checkVal("b2b byte count", 16'(gotBytes.size()), 16'd6);
        if (gotBytes.size() == 6) begin
            for (int i = 0; i < 6; i++) checkVal("b2b byte", {8'h0, gotBytes[i]}, 16'(i + 1));
            checkVal("b2b span", 16'(gotCycles[5] - gotCycles[0]), 16'(expSpan));
        end

        // Reset during the second byte of CAFE.
        applyStimulus(1'b1, 16'hCAFE, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkVal("cafe second", {6'h0, loadHighA, loadLowA, halfA}, {6'h0, 2'b01, 8'hFE});
        #2;
        reset = 1'b0;
        modelQ.delete();
        modelSent = 0;
        asmA = 16'h0000;
        #1;
        checkVal("async strobes A", {14'h0, loadHighA, loadLowA}, 16'h0000);
        checkVal("async strobes B", {14'h0, loadHighB, loadLowB}, 16'h0000);
        checkOutput();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        sendWord(vecs[5]);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 149) == 0) begin
                doReset();
            end else begin
                applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) != 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/word_splitter_16bit.md
# word_splitter_16bit

Splits 16-bit words into two 8-bit transfers and drives them onto the byte-load interface of the 16-bit half-loaded register: `halfvalueout` plus `loadhigh`/`loadlow` strobes. It accepts words over a valid/ready handshake and stalls on downstream `byteready`. It sits between the 16-bit datapath and any 8-bit bus or half-loaded register, and is the write-side counterpart of that register.

## Interface
- `HIGH_FIRST`, default 1: 1 = high byte (`loadhigh`) sent first; 0 = low byte (`loadlow`) sent first.
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `wordvalid` in 1: `wordin` holds a word to send.
- `wordin` in 16: word to split.
- `wordready` out 1: the block takes a word at an edge where `wordvalid && wordready`.
- `halfvalueout` out 8: byte currently presented.
- `loadhigh` out 1: `halfvalueout` is `wordin[15:8]` of the active word.
- `loadlow` out 1: `halfvalueout` is `wordin[7:0]` of the active word.
- `byteready` in 1: downstream takes the presented byte at an edge where a strobe and `byteready` are both high. Tie it high for a register that is always ready.
- `busy` out 1: high when state is not IDLE or when the holding register is valid.

## Operation
- FSM states: IDLE, SEND_FIRST, SEND_SECOND. State, active word register and outputs are all registered.
- IDLE: strobes 0, `halfvalueout` = 8'h00.
  - On acceptance, load `wordin` into the active register and go to SEND_FIRST.
- SEND_FIRST: present the first byte and assert its strobe.
  - On `byteready`, go to SEND_SECOND.
  - Otherwise hold all outputs stable.
- SEND_SECOND: present the second byte and assert the other strobe.
  - On `byteready`, go to IDLE, or reload per Configuration.
- Strobes are mutually exclusive. At most one is high, and never both in any state.
- A stall (`byteready`=0) can last any length. Byte value and strobe do not change during it.
- `wordin` is sampled only at acceptance. Later changes have no effect on the bytes being sent.
- Reset at any point, including mid-word:
  - state → IDLE; active register, holding register and valid flag cleared.
  - All outputs at reset values. A partially sent word is discarded.
- Reset values: `wordready`=1, `loadhigh`=0, `loadlow`=0, `halfvalueout`=8'h00, `busy`=0.

## Timing
- Word accepted at edge N:
  - First byte and strobe are visible after edge N.
  - First byte transfers at edge N+1 if `byteready`=1.
  - Second byte transfers at edge N+2.
- Each cycle with `byteready`=0 adds one cycle of latency.
- Without prefetch:
  - `wordready` = (state == IDLE).
  - Next acceptance is no earlier than edge N+3, so sustained throughput is 1 word per 3 cycles.
- With prefetch: sustained throughput is 1 word per 2 cycles, with no gap between the second byte of one word and the first byte of the next.
- `wordready` and `busy` are decoded from registered state only. There is no combinational path from `wordvalid` or `byteready` to any output.

## Configuration
- Macro `WORD_SPLITTER_PREFETCH_EN`.
- Defined: adds a one-word holding register and a `holdvalid` flag.
  - `wordready` = !`holdvalid` in every state.
  - In IDLE, an accepted word loads the active register directly.
  - In SEND_FIRST or SEND_SECOND, an accepted word loads the holding register.
  - Exception: when the second byte transfers and a word is accepted on the same edge with the hold empty, that word loads the active register directly.
  - When the second byte transfers and `holdvalid`=1, move hold to active, clear `holdvalid`, and go to SEND_FIRST.
  - Otherwise, after the second byte transfers, go to IDLE.
- Undefined: no holding register, `wordready` is high only in IDLE, and a word is never accepted during a send.

## Test plan
- Reset sequence: reset low for 2 cycles, then release.
  - Required: `wordready`=1, strobes 0, `halfvalueout`=8'h00, `busy`=0.
- Single word, `wordin`=16'hA55A, `byteready`=1, `HIGH_FIRST`=1:
  - Required: `loadhigh` with 8'hA5 for one cycle, then `loadlow` with 8'h5A for one cycle, then back to IDLE.
  - Feeding these outputs into the register yields 16'hA55A.
- Stall: send 16'h1234 and hold `byteready`=0 for 4 cycles during SEND_FIRST.
  - Required: 8'h12 with `loadhigh` stays stable for all 4 cycles.
  - 8'h34 follows only after `byteready` rises.
- `HIGH_FIRST`=0 with 16'hBEEF:
  - Required: `loadlow` with 8'hEF first, then `loadhigh` with 8'hBE.
- Back-to-back words 16'h0102, 16'h0304, 16'h0506 with `wordvalid` held high:
  - With `WORD_SPLITTER_PREFETCH_EN`: bytes 01,02,03,04,05,06 on consecutive cycles.
  - Without the macro: one idle cycle between words.
- Reset asserted during SEND_SECOND of 16'hCAFE:
  - Required: strobes drop immediately (asynchronously) and the low byte is never emitted.
  - After release, 16'h0BAD is sent cleanly as 8'h0B then 8'hAD.
